rgmii_send: RTL
===============

Name: rgmii_send

Overview:
Transmit-side Ethernet framer for the 1000T RGMII path, the counterpart of the receive demux/preamble detector. It accepts a frame as a byte stream with a valid/ready/last handshake. It emits the GMII byte sequence: preamble, SFD, payload, zero pad, CRC32 FCS, then an enforced inter-frame gap. Output bytes plus enable/error go to the DDR output stage (ddio_out), which splits each byte into PHY nibbles.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (1..15).
MIN_PAYLOAD, 60, minimum payload bytes before FCS; shorter frames are zero-padded when PAD_EN=1.
PAD_EN, 1, 1 = pad short frames to MIN_PAYLOAD; 0 = no padding.
IFG_BYTES, 12, minimum clock cycles with phy_en low between frames (1..31).

Ports:
clock  in  1  125 MHz GMII byte clock; all logic on rising edge.
reset_n  in  1  synchronous, active-low reset.
tx_data  in  8  payload byte from upstream.
tx_valid  in  1  tx_data valid.
tx_last  in  1  tx_data is the final payload byte of the frame.
tx_ready  out  1  block accepts tx_data this cycle (beat = tx_valid & tx_ready).
phy_data  out  8  byte to DDR output stage, bits [3:0] sent first.
phy_en  out  1  TX_EN to DDR output stage.
phy_er  out  1  TX_ER to DDR output stage.
underrun  out  1  one-cycle pulse: frame aborted because upstream starved.
tx_done  out  1  one-cycle pulse on the cycle the last FCS byte is on phy_data.

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE; phy_data=0x00, phy_en=0, phy_er=0, tx_ready=0, underrun=0, tx_done=0; IFG counter cleared (a frame may start immediately after reset). A reset mid-frame truncates the frame with no FCS and no phy_er.
- phy_data, phy_en, phy_er, underrun and tx_done are registered. tx_ready is a decode of the current state only and never depends on tx_valid.
- States:
  - IDLE: phy_en=0. When tx_valid=1 and the IFG counter is 0, go to PRE.
  - PRE: PREAMBLE_LEN cycles of phy_data=0x55, phy_en=1, then go to SFD.
  - SFD: phy_data=0xD5; tx_ready=1. Byte counter and CRC are initialised (CRC=0xFFFFFFFF).
  - DATA: tx_ready=1. Each accepted beat appears on phy_data exactly one cycle later, so the payload is contiguous with the SFD.
  - PAD: after the tx_last beat, if PAD_EN=1 and the byte count is below MIN_PAYLOAD, emit 0x00 until the count equals MIN_PAYLOAD; otherwise go straight to FCS.
  - FCS: 4 bytes.
  - IFG: phy_en=0 for IFG_BYTES cycles, then IDLE.
  - DRAIN: see underrun.
- tx_ready drops the cycle after the tx_last beat is accepted.
- CRC32: reflected polynomial 0xEDB88320, LSB-first per byte, covers payload and pad bytes. FCS = ~crc, sent as bytes [7:0], [15:8], [23:16], [31:24]. The pad and FCS bytes immediately follow the last payload byte with no gap.
- tx_done is high on the cycle phy_data carries FCS byte 3; the following cycle phy_en=0.
- Byte counter: 11 bits, saturates at 2047; no maximum-length enforcement.
- Underrun: tx_valid=0 in a cycle where tx_ready=1 (SFD or DATA):
  - next cycle: phy_en=1, phy_er=1, phy_data=0x00 for one cycle; underrun pulses.
  - then DRAIN: phy_en=0, tx_ready=1, beats are discarded until the tx_last beat is accepted, then IFG.
  - No FCS is sent.
- tx_last accepted in the SFD cycle gives a 1-byte payload (padded if PAD_EN=1).
- The IFG counter loads IFG_BYTES on the first phy_en=0 cycle after a frame or abort. Back-to-back frames therefore have exactly IFG_BYTES idle cycles when tx_valid is already high.
- phy_data=0x00 whenever phy_en=0.

Test Plan:
- PAD_EN=0, payload ASCII "123456789" (0x31..0x39) with tx_valid held high -> phy_data sequence 55×7, D5, 31..39, 26 39 F4 CB; phy_en high for exactly 21 cycles; tx_done on the 0xCB cycle; tx_ready high for exactly 9 cycles.
- PAD_EN=1, 14-byte payload -> 46 bytes of 0x00 follow the payload, then 4 FCS bytes matching a reference CRC32 over 60 bytes; phy_en high 72 cycles.
- Two frames queued back-to-back -> exactly 12 cycles of phy_en=0 between the last FCS byte of frame 1 and the first 0x55 of frame 2.
- Deassert tx_valid on payload byte 5 of a 100-byte frame -> one cycle with phy_er=1, phy_en=1; underrun pulses once; phy_en low through the remaining 95 beats (all accepted, none transmitted); no FCS; next frame starts after IFG.
- Assert reset_n=0 for one cycle during FCS byte 1 -> next cycle phy_en=0, tx_ready=0; a frame offered immediately after reset starts with 0x55 on the cycle after IDLE sees tx_valid.
- tx_last on the first beat (1-byte payload 0xAB, PAD_EN=1) -> D5, AB, 59×0x00, 4 FCS bytes; tx_ready high for 1 cycle only.

Source files
------------

// File: rtl/rgmii_send.sv
// GMII transmit framer for the 1000T RGMII path: preamble, SFD, payload, zero pad,
// CRC32 FCS and an enforced inter-frame gap. Bytes feed ddio_out for nibble splitting.
module rgmii_send #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_PAYLOAD  = 60,
   parameter bit PAD_EN       = 1'b1,
   parameter int IFG_BYTES    = 12
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] phy_data,
   output logic       phy_en,
   output logic       phy_er,
   output logic       underrun,
   output logic       tx_done
);

   localparam logic [3:0]  PRE_LAST  = 4'(PREAMBLE_LEN);
   localparam logic [10:0] MIN_CNT   = 11'(MIN_PAYLOAD);
   localparam logic [4:0]  IFG_LD    = 5'(IFG_BYTES);
   localparam logic [4:0]  IFG_LD_M1 = 5'(IFG_BYTES - 1);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN} state_t;

   state_t      state;
   logic [3:0]  pre_cnt;
   logic [10:0] byte_cnt;
   logic [10:0] cnt_inc;
   logic [31:0] crc;
   logic [31:0] fcs;
   logic [1:0]  fcs_idx;
   logic [4:0]  ifg_cnt;

   // Reflected CRC32 (0xEDB88320), one byte LSB-first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign cnt_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
   assign fcs      = ~crc;
   assign tx_ready = (state == SFD) || (state == DATA) || (state == DRAIN);

   // Every output register holds the value for the cycle owned by the state entered
   // at the same edge, so an accepted beat shows on phy_data exactly one cycle later.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         phy_data <= 8'h00;
         phy_en   <= 1'b0;
         phy_er   <= 1'b0;
         underrun <= 1'b0;
         tx_done  <= 1'b0;
         pre_cnt  <= 4'd0;
         byte_cnt <= 11'd0;
         crc      <= 32'hFFFFFFFF;
         fcs_idx  <= 2'd0;
         ifg_cnt  <= 5'd0;
      end else begin
         phy_data <= 8'h00;
         phy_en   <= 1'b0;
         phy_er   <= 1'b0;
         underrun <= 1'b0;
         tx_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid && ifg_cnt == 5'd0) begin
                  state    <= PRE;
                  phy_en   <= 1'b1;
                  phy_data <= 8'h55;
                  pre_cnt  <= 4'd1;
               end
            end
            PRE: begin
               phy_en <= 1'b1;
               if (pre_cnt == PRE_LAST) begin
                  state    <= SFD;
                  phy_data <= 8'hD5;
                  crc      <= 32'hFFFFFFFF;
                  byte_cnt <= 11'd0;
               end else begin
                  phy_data <= 8'h55;
                  pre_cnt  <= pre_cnt + 4'd1;
               end
            end
            SFD, DATA: begin
               phy_en <= 1'b1;
               if (tx_valid) begin
                  phy_data <= tx_data;
                  crc      <= crc_byte(crc, tx_data);
                  byte_cnt <= cnt_inc;
                  fcs_idx  <= 2'd0;
                  if (tx_last)
                     state <= (PAD_EN && cnt_inc < MIN_CNT) ? PAD : FCS;
                  else
                     state <= DATA;
               end else begin
                  // Upstream starved mid-frame: poison the frame with one TX_ER byte.
                  phy_er   <= 1'b1;
                  underrun <= 1'b1;
                  state    <= DRAIN;
               end
            end
            PAD: begin
               phy_en   <= 1'b1;
               crc      <= crc_byte(crc, 8'h00);
               byte_cnt <= cnt_inc;
               if (cnt_inc >= MIN_CNT)
                  state <= FCS;
            end
            FCS: begin
               phy_en   <= 1'b1;
               phy_data <= fcs[{fcs_idx, 3'b000} +: 8];
               fcs_idx  <= fcs_idx + 2'd1;
               if (fcs_idx == 2'd3) begin
                  tx_done <= 1'b1;
                  state   <= IFG;
                  ifg_cnt <= IFG_LD;
               end
            end
            IFG: begin
               if (ifg_cnt <= 5'd1) begin
                  state   <= IDLE;
                  ifg_cnt <= 5'd0;
               end else begin
                  ifg_cnt <= ifg_cnt - 5'd1;
               end
            end
            DRAIN: begin
               // Cycle after the final discarded beat is already the first idle cycle.
               if (tx_valid && tx_last) begin
                  state   <= IFG;
                  ifg_cnt <= IFG_LD_M1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
